// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor writing a length-prefixed ciphertext.
//   Reads a length-prefixed plaintext from pt memory, runs S-box init, key
//   scheduling and keystream generation through an external 256x8 S memory,
//   and writes ct[0]=L followed by ct[k]=pt[k]^pad for k=1..L.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en, rdy, key      start handshake; key latched on accepted en
//   pt_addr/pt_rddata plaintext read port (1-cycle read latency)
//   ct_addr/ct_wrdata/ct_wren   ciphertext write port
//   s_addr/s_rddata/s_wrdata/s_wren  S memory port (1-cycle read latency)
//   bad_pt            sticky non-printable-plaintext flag
// Build option: define ARC4_ENC_PT_CHECK_EN to enable the bad_pt check;
//   otherwise bad_pt is tied low.
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  output logic        bad_pt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    KSA  = 3'd2,
    LEN  = 3'd3,
    PRGA = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  ph;
  logic [23:0] key_r;
  logic [7:0]  i, j, k, len;
  logic [7:0]  si, sj, ptk;
  logic [1:0]  kidx;     // i mod 3, tracked incrementally during KSA
  logic [7:0]  key_byte;
  logic [7:0]  j_next;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = key_r[23:16];
      2'd1:    key_byte = key_r[15:8];
      default: key_byte = key_r[7:0];
    endcase
    j_next = j + s_rddata;
    if (state == KSA) j_next = j_next + key_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ph    <= '0;
      key_r <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      ptk   <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          key_r <= key;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          ph    <= '0;
          state <= INIT;
        end
        INIT: begin
          i <= i + 8'd1;   // wraps to 0 for KSA
          if (i == 8'hFF) begin
            j     <= '0;
            kidx  <= '0;
            ph    <= '0;
            state <= KSA;
          end
        end
        KSA: case (ph)
          3'd0: ph <= 3'd1;
          3'd1: begin
            si <= s_rddata;
            j  <= j_next;
            ph <= 3'd2;
          end
          3'd2: begin
            sj <= s_rddata;
            ph <= 3'd3;
          end
          default: begin
            ph   <= 3'd0;
            i    <= i + 8'd1;
            kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
            if (i == 8'hFF) state <= LEN;
          end
        endcase
        LEN: begin
          if (ph == 3'd0) begin
            ph <= 3'd1;
          end else begin
            ph  <= 3'd0;
            len <= pt_rddata;
            if (pt_rddata == 8'd0) begin
              state <= DONE;
            end else begin
              i     <= '0;
              j     <= '0;
              k     <= 8'd1;
              state <= PRGA;
            end
          end
        end
        PRGA: case (ph)
          3'd0: begin
            i  <= i + 8'd1;   // later phases address S with the advanced i
            ph <= 3'd1;
          end
          3'd1: begin
            si  <= s_rddata;
            ptk <= pt_rddata;
            j   <= j_next;
            ph  <= 3'd2;
          end
          3'd2: begin
            sj <= s_rddata;
            ph <= 3'd3;
          end
          3'd3: ph <= 3'd4;
          3'd4: ph <= 3'd5;
          default: begin
            ph <= 3'd0;
            // k stops at len so L=255 never wraps
            if (k == len) state <= DONE;
            else          k <= k + 8'd1;
          end
        endcase
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Swap writes use the held si and the live S[j] read, so i==j rewrites
  // the same value twice and S is left unchanged.
  always_comb begin
    rdy       = (state == IDLE);
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    case (state)
      INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
      end
      KSA, PRGA: case (ph)
        3'd0: begin
          s_addr = (state == PRGA) ? i + 8'd1 : i;
          if (state == PRGA) pt_addr = k;
        end
        3'd1: s_addr = j_next;
        3'd2: begin
          s_addr   = i;
          s_wrdata = s_rddata;
          s_wren   = 1'b1;
        end
        3'd3: begin
          s_addr   = j;
          s_wrdata = si;
          s_wren   = 1'b1;
        end
        3'd4: s_addr = si + sj;
        default: begin
          ct_addr   = k;
          ct_wrdata = ptk ^ s_rddata;
          ct_wren   = 1'b1;
        end
      endcase
      LEN: if (ph == 3'd1) begin
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARC4_ENC_PT_CHECK_EN
  logic bad_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_r <= 1'b0;
    end else if (state == IDLE && en) begin
      bad_r <= 1'b0;
    end else if (state == PRGA && ph == 3'd1 &&
                 (pt_rddata < 8'h20 || pt_rddata > 8'h7E)) begin
      bad_r <= 1'b1;
    end
  end
  assign bad_pt = bad_r;
`else
  assign bad_pt = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr, s_rddata, s_wrdata;
  logic        s_wren;
  logic        bad_pt;

  arc4_encrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .bad_pt(bad_pt)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle synchronous read
  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  s_mem  [256];
  int unsigned ct_writes = 0;

  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_writes <= ct_writes + 1;
    end
  end

  // Reference ARC4 model
  logic [7:0]  m_s  [256];
  logic [7:0]  m_ct [256];
  int unsigned m_first_bad;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ref_model(input logic [23:0] kk);
    int unsigned ii, jj, L;
    logic [7:0]  kb [3];
    logic [7:0]  t;
    kb[0] = kk[23:16];
    kb[1] = kk[15:8];
    kb[2] = kk[7:0];
    for (int unsigned n = 0; n < 256; n++) m_s[n] = n[7:0];
    jj = 0;
    for (ii = 0; ii < 256; ii++) begin
      jj = (jj + m_s[ii] + kb[ii % 3]) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
    end
    L = pt_mem[0];
    m_ct[0] = pt_mem[0];
    ii = 0;
    jj = 0;
    m_first_bad = 0;
    for (int unsigned n = 1; n <= L; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + m_s[ii]) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      m_ct[n] = pt_mem[n] ^ m_s[(m_s[ii] + m_s[jj]) % 256];
      // flag visible from the negedge after byte n is captured
      if ((pt_mem[n] < 8'h20 || pt_mem[n] > 8'h7E) && m_first_bad == 0)
        m_first_bad = 1284 + 6 * (n - 1);
    end
`ifndef ARC4_ENC_PT_CHECK_EN
    m_first_bad = 0;
`endif
  endtask

  task automatic fill_pt(input int unsigned len, input int unsigned mode);
    string hello = "hello";
    pt_mem[0] = len[7:0];
    for (int unsigned n = 1; n <= len; n++) begin
      case (mode)
        1:       pt_mem[n] = hello[n-1];
        3:       pt_mem[n] = 8'($urandom);
        default: pt_mem[n] = 8'($urandom_range(32, 126));
      endcase
    end
    if (mode == 2) pt_mem[4] = 8'h0A;
  endtask

  task automatic start_en(input logic [23:0] k_in);
    @(negedge clk);
    key = k_in;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic run_enc(input string name, input logic [23:0] k_in,
                         input int unsigned exp_cyc, input bit inject);
    int unsigned cyc, first_bad, w0, L;
    L = pt_mem[0];
    ref_model(k_in);
    w0 = ct_writes;
    start_en(k_in);
    chk({name, " bad_pt_cleared"}, 32'(bad_pt), 32'd0);
    cyc = 0;
    first_bad = 0;
    while (!rdy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 1290) begin en = 1'b1; key = ~k_in; end
      if (inject && cyc == 1291) en = 1'b0;
      if (bad_pt && first_bad == 0) first_bad = cyc;
    end
    chk({name, " latency"}, cyc, exp_cyc);
    chk({name, " ct_write_count"}, ct_writes - w0, L + 1);
    for (int unsigned n = 0; n <= L; n++)
      chk($sformatf("%s ct[%0d]", name, n), 32'(ct_mem[n]), 32'(m_ct[n]));
    for (int unsigned n = 0; n < 256; n++)
      chk($sformatf("%s S[%0d]", name, n), 32'(s_mem[n]), 32'(m_s[n]));
    chk({name, " bad_pt_first_cycle"}, first_bad, m_first_bad);
    chk({name, " bad_pt_final"}, 32'(bad_pt), 32'(m_first_bad != 0));
  endtask

  typedef struct {
    logic [23:0] key;
    int unsigned len;
    int unsigned mode;     // 0 printable, 1 "hello", 2 printable + 0x0A, 3 any byte
    int unsigned exp_cyc;  // 1283 + 6*len
  } vec_t;

  vec_t        tbl [6];
  logic [7:0]  orig [256];
  int unsigned w0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int unsigned n = 0; n < 256; n++) pt_mem[n] = '0;
    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rdy", 32'(rdy), 32'd1);
    chk("reset ct_wren", 32'(ct_wren), 32'd0);
    chk("reset s_wren", 32'(s_wren), 32'd0);
    chk("reset bad_pt", 32'(bad_pt), 32'd0);
    chk("reset addrs", {8'(s_addr), 8'(pt_addr), 8'(ct_addr), 8'd0}, 32'd0);
    chk("reset wrdata", {16'd0, ct_wrdata, s_wrdata}, 32'd0);

    tbl[0] = '{24'h000000, 0, 0, 1283};
    tbl[1] = '{24'h1E4600, 5, 1, 1313};
    tbl[2] = '{24'($urandom), 17, 0, 1385};
    tbl[3] = '{24'($urandom), 64, 3, 1667};
    tbl[4] = '{24'($urandom), 12, 2, 1355};
    tbl[5] = '{24'h0ABCDE, 1, 0, 1289};
    for (int unsigned t = 0; t < 6; t++) begin
      fill_pt(tbl[t].len, tbl[t].mode);
      run_enc($sformatf("vec%0d", t), tbl[t].key, tbl[t].exp_cyc, 1'b0);
    end

    // Symmetry: encrypting the ciphertext with the same key restores pt
    fill_pt(255, 0);
    for (int unsigned n = 0; n < 256; n++) orig[n] = pt_mem[n];
    run_enc("sym_pass1", 24'hFFFFFF, 2813, 1'b0);
    for (int unsigned n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
    run_enc("sym_pass2", 24'hFFFFFF, 2813, 1'b0);
    for (int unsigned n = 1; n < 256; n++)
      chk($sformatf("sym roundtrip[%0d]", n), 32'(ct_mem[n]), 32'(orig[n]));

    // en with a different key during PRGA is ignored
    fill_pt(20, 0);
    run_enc("busy_en", 24'h123456, 1403, 1'b1);

    // Reset mid-KSA aborts immediately
    fill_pt(8, 0);
    start_en(24'hC0FFEE);
    repeat (500) @(negedge clk);
    w0 = ct_writes;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_during s_wren", 32'(s_wren), 32'd0);
    chk("rst_during rdy", 32'(rdy), 32'd1);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after rdy", 32'(rdy), 32'd1);
    chk("rst_after s_wren", 32'(s_wren), 32'd0);
    chk("rst_after ct_wren", 32'(ct_wren), 32'd0);
    chk("rst_after no_ct_writes", ct_writes - w0, 32'd0);
    run_enc("after_rst", 24'hC0FFEE, 1331, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
